// File: rtl/mandelbrot_coords_ml_if.sv
// Beat stream from the coordinate generator to the parallel iteration engines.
// The master drives the beat contents; the slave returns ready.
interface mandelbrot_coords_ml_if #(
    parameter int AW    = 20,
    parameter int FPW   = 27,
    parameter int LANES = 4
);
    logic                 out_vld;
    logic                 out_rdy;
    logic [LANES-1:0]     out_mask;
    logic                 out_eol;
    logic                 out_eof;
    logic [LANES*FPW-1:0] x;
    logic [FPW-1:0]       y;
    logic [AW-1:0]        adr;

    modport master (output out_vld, out_mask, out_eol, out_eof, x, y, adr, input out_rdy);
    modport slave  (input out_vld, out_mask, out_eol, out_eof, x, y, adr, output out_rdy);
endinterface

// File: rtl/mandelbrot_coords_ml.sv
// Multi-lane windowed Mandelbrot coordinate generator: LANES adjacent pixels per
// beat with framebuffer address, lane mask and row/frame markers.
module mandelbrot_coords_ml #(
    parameter int CW    = 12,
    parameter int AW    = 20,
    parameter int FPW   = 27,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  abort,
    output logic                  done,
    input  logic [CW-1:0]         width,
    input  logic [CW-1:0]         height,
    input  logic [AW-1:0]         adr0,
    input  logic [AW-1:0]         stride,
    input  logic signed [FPW-1:0] man_x0,
    input  logic signed [FPW-1:0] man_y0,
    input  logic signed [FPW-1:0] man_xs,
    input  logic signed [FPW-1:0] man_ys,
    mandelbrot_coords_ml_if.master beat
);
    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         width_r, height_r;
    logic [AW-1:0]         adr0_r, stride_r, row_adr, adr_r;
    logic signed [FPW-1:0] x0_r, y0_r, xs_r, ys_r, step_x, acc, acc_nxt, y_r;
    logic signed [FPW-1:0] off_r [LANES];
    logic signed [FPW-1:0] x_r   [LANES];
    logic [KW-1:0]         k;
    logic [CW:0]           col, col_nxt;
    logic [CW-1:0]         row, row_nxt;
    logic [LANES-1:0]      mask_r;
    logic                  eol_r, eof_r;
    logic [LANES+1:0]      flags_nxt;
    logic                  start;

    // {mask, eol, eof} for the beat starting at column c of row r
    function automatic logic [LANES+1:0] beat_flags(input logic [CW:0] c, input logic [CW-1:0] r,
                                                    input logic [CW-1:0] w, input logic [CW-1:0] h);
        logic [LANES-1:0] m;
        logic             e;
        for (int i = 0; i < LANES; i++)
            m[i] = (c + (CW+1)'(i)) < {1'b0, w};
        e = (c + (CW+1)'(LANES)) >= {1'b0, w};
        return {m, e, e && (r == h - CW'(1))};
    endfunction

    assign start   = init && (width != '0) && (height != '0);
    assign acc_nxt = acc + xs_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (LANES == 1) ? RUN : PREP;
            PREP:    if (k == K_LAST) state_nxt = RUN;
            RUN:     if (beat.out_rdy && eof_r) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        col_nxt = col + (CW+1)'(LANES);
        row_nxt = row;
        if (eol_r) begin
            col_nxt = '0;
            row_nxt = row + CW'(1);
        end
        flags_nxt = beat_flags(col_nxt, row_nxt, width_r, height_r);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    // Visible beat registers; reset and abort act here
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
            eol_r  <= 1'b0;
            eof_r  <= 1'b0;
            y_r    <= '0;
            adr_r  <= '0;
            for (int i = 0; i < LANES; i++) x_r[i] <= '0;
        end else if (clk_en) begin
            if (abort) begin
                mask_r <= '0;
                eol_r  <= 1'b0;
                eof_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && LANES == 1) begin
                        x_r[0] <= man_x0;
                        y_r    <= man_y0;
                        adr_r  <= adr0;
                        {mask_r, eol_r, eof_r} <= beat_flags('0, '0, width, height);
                    end
                    PREP: if (k == K_LAST) begin
                        for (int i = 0; i < LANES; i++)
                            x_r[i] <= x0_r + ((i == LANES - 1) ? acc_nxt : off_r[i]);
                        y_r   <= y0_r;
                        adr_r <= adr0_r;
                        {mask_r, eol_r, eof_r} <= beat_flags('0, '0, width_r, height_r);
                    end
                    RUN: if (beat.out_rdy) begin
                        if (eof_r) begin
                            {mask_r, eol_r, eof_r} <= '0;
                        end else begin
                            {mask_r, eol_r, eof_r} <= flags_nxt;
                            if (eol_r) begin
                                y_r   <= y_r + ys_r;
                                adr_r <= row_adr + stride_r;
                                for (int i = 0; i < LANES; i++) x_r[i] <= x0_r + off_r[i];
                            end else begin
                                adr_r <= adr_r + AW'(LANES);
                                for (int i = 0; i < LANES; i++) x_r[i] <= x_r[i] + step_x;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame configuration, lane offsets and scan position; only meaningful outside IDLE
    always_ff @(posedge clk) begin
        if (clk_en) begin
            case (state)
                IDLE: if (start) begin
                    width_r  <= width;
                    height_r <= height;
                    adr0_r   <= adr0;
                    stride_r <= stride;
                    x0_r     <= man_x0;
                    y0_r     <= man_y0;
                    xs_r     <= man_xs;
                    ys_r     <= man_ys;
                    off_r[0] <= '0;
                    acc      <= '0;
                    k        <= KW'(1);
                    col      <= '0;
                    row      <= '0;
                    row_adr  <= adr0;
                    step_x   <= man_xs;
                end
                PREP: begin
                    off_r[k] <= acc_nxt;
                    acc      <= acc_nxt;
                    k        <= k + KW'(1);
                    if (k == K_LAST) step_x <= acc_nxt + xs_r;
                end
                RUN: if (beat.out_rdy && !eof_r) begin
                    col <= col_nxt;
                    row <= row_nxt;
                    if (eol_r) row_adr <= row_adr + stride_r;
                end
                default: ;
            endcase
        end
    end

    assign done          = (state == IDLE);
    assign beat.out_vld  = (state == RUN);
    assign beat.out_mask = mask_r;
    assign beat.out_eol  = eol_r;
    assign beat.out_eof  = eof_r;
    assign beat.y        = y_r;
    assign beat.adr      = adr_r;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign beat.x[i*FPW +: FPW] = x_r[i];
    end
endmodule

// File: tb/tb_mandelbrot_coords_ml.sv
// Bench for mandelbrot_coords_ml: a LANES=1 and a LANES=4 instance checked
// against a per-pixel arithmetic reference of the window scan.
module tb_mandelbrot_coords_ml;
    localparam int CW  = 12;
    localparam int AW  = 20;
    localparam int FPW = 27;

    typedef struct packed {
        logic [3:0]       mask;
        logic             eol;
        logic             eof;
        logic [4*FPW-1:0] x;
        logic [FPW-1:0]   y;
        logic [AW-1:0]    adr;
    } beat_t;

    logic           clk = 1'b0;
    logic           clk_en = 1'b1, rst = 1'b1, init = 1'b0, abort = 1'b0, rdy = 1'b0;
    logic [CW-1:0]  width = '0, height = '0;
    logic [AW-1:0]  adr0 = '0, stride = '0;
    logic [FPW-1:0] x0 = '0, y0 = '0, xs = '0, ys = '0;
    logic           done1, done4;
    int             sel = 0;
    int             n_cmp = 0, n_bad = 0;
    beat_t          exp_q[$];
    beat_t          obs;
    logic           s_vld, s_done;

    always #5 clk = ~clk;

    mandelbrot_coords_ml_if #(.AW(AW), .FPW(FPW), .LANES(1)) if1 ();
    mandelbrot_coords_ml_if #(.AW(AW), .FPW(FPW), .LANES(4)) if4 ();
    assign if1.out_rdy = rdy;
    assign if4.out_rdy = rdy;

    mandelbrot_coords_ml #(.CW(CW), .AW(AW), .FPW(FPW), .LANES(1)) u_l1 (
        .clk(clk), .clk_en(clk_en), .rst(rst), .init(init && sel == 0), .abort(abort && sel == 0),
        .done(done1), .width(width), .height(height), .adr0(adr0), .stride(stride),
        .man_x0(x0), .man_y0(y0), .man_xs(xs), .man_ys(ys), .beat(if1));

    mandelbrot_coords_ml #(.CW(CW), .AW(AW), .FPW(FPW), .LANES(4)) u_l4 (
        .clk(clk), .clk_en(clk_en), .rst(rst), .init(init && sel == 1), .abort(abort && sel == 1),
        .done(done4), .width(width), .height(height), .adr0(adr0), .stride(stride),
        .man_x0(x0), .man_y0(y0), .man_xs(xs), .man_ys(ys), .beat(if4));

    always_comb begin
        if (sel == 1) begin
            s_vld  = if4.out_vld;
            s_done = done4;
            obs    = {if4.out_mask, if4.out_eol, if4.out_eof, if4.x, if4.y, if4.adr};
        end else begin
            s_vld  = if1.out_vld;
            s_done = done1;
            obs    = {3'b000, if1.out_mask, if1.out_eol, if1.out_eof, {(3*FPW){1'b0}}, if1.x, if1.y, if1.adr};
        end
    end

    // Pixel (c, r) of the window sits at x0 + c*xs, y0 + r*ys, adr0 + r*stride + c
    task automatic build_expected(input int lanes);
        beat_t b;
        exp_q.delete();
        for (int r = 0; r < int'(height); r++) begin
            for (int c = 0; c < int'(width); c += lanes) begin
                b = '0;
                for (int i = 0; i < lanes; i++) begin
                    b.mask[i] = (c + i < int'(width));
                    b.x[i*FPW +: FPW] = FPW'(longint'(x0) + longint'(c + i) * longint'(xs));
                end
                b.eol = (c + lanes >= int'(width));
                b.eof = b.eol && (r == int'(height) - 1);
                b.y   = FPW'(longint'(y0) + longint'(r) * longint'(ys));
                b.adr = AW'(longint'(adr0) + longint'(r) * longint'(stride) + longint'(c));
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int ax, input int sx, input int ay,
                           input int sy, input int a0, input int st);
        width = CW'(w); height = CW'(h);
        x0 = FPW'(ax); xs = FPW'(sx); y0 = FPW'(ay); ys = FPW'(sy);
        adr0 = AW'(a0); stride = AW'(st);
    endtask

    task automatic rand_cfg(input int maxw, input int maxh);
        width  = CW'($urandom_range(1, maxw));
        height = CW'($urandom_range(1, maxh));
        x0 = FPW'($urandom); xs = FPW'($urandom);
        y0 = FPW'($urandom); ys = FPW'($urandom);
        adr0 = AW'($urandom); stride = AW'($urandom);
    endtask

    task automatic run_frame(input int rdy_pct, input bit do_stall, input bit b2b);
        int    lanes, n, lat, stalls;
        bit    fin, have_held, en, go;
        beat_t held;
        lanes = (sel == 1) ? 4 : 1;
        build_expected(lanes);
        n = 0; lat = -1; stalls = 0; fin = 0; have_held = 0; held = '0;
        @(negedge clk); clk_en = 1'b1; rdy = 1'b0; init = 1'b1;
        @(negedge clk); init = 1'b0;
        n_cmp++;
        if (s_done !== 1'b0) begin n_bad++; $display("FAIL init_done sel=%0d: got %b want 0", sel, s_done); end
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (s_vld === 1'b1 && lat < 0) lat = cyc;
            if (have_held) begin
                n_cmp++;
                if (obs !== held || s_vld !== 1'b1) begin
                    n_bad++;
                    $display("FAIL hold sel=%0d beat=%0d: got vld=%b %h want vld=1 %h", sel, n, s_vld, obs, held);
                end
            end
            en = !(do_stall && n >= 3 && stalls < 3);
            if (!en) stalls++;
            go = ($urandom_range(99) < rdy_pct);
            clk_en = en; rdy = go;
            have_held = 0;
            if (s_vld === 1'b1) begin
                if (en && go) begin
                    n_cmp++;
                    if (n >= exp_q.size()) begin
                        n_bad++; $display("FAIL extra_beat sel=%0d: got beat %0d want only %0d beats", sel, n, exp_q.size());
                    end else if (obs !== exp_q[n]) begin
                        n_bad++; $display("FAIL beat sel=%0d idx=%0d: got %h want %h", sel, n, obs, exp_q[n]);
                    end
                    n++;
                    if (obs.eof === 1'b1) begin
                        fin = 1;
                        if (b2b) init = 1'b1;
                    end
                end else begin
                    held = obs; have_held = 1;
                end
            end
        end
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL timeout sel=%0d: got %0d beats, eof never seen, want %0d", sel, n, exp_q.size()); end
        n_cmp++;
        if (lat !== lanes - 1) begin n_bad++; $display("FAIL latency sel=%0d: got %0d want %0d", sel, lat, lanes - 1); end
        n_cmp++;
        if (n !== exp_q.size()) begin n_bad++; $display("FAIL beat_count sel=%0d: got %0d want %0d", sel, n, exp_q.size()); end
        @(negedge clk); clk_en = 1'b1; rdy = 1'b0;
        n_cmp++;
        if (s_vld !== 1'b0 || s_done !== 1'b1 || obs.mask !== 4'b0 || obs.eol !== 1'b0 || obs.eof !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end sel=%0d: got vld=%b done=%b mask=%b eol=%b eof=%b want 0 1 0 0 0",
                     sel, s_vld, s_done, obs.mask, obs.eol, obs.eof);
        end
        if (b2b) begin
            @(negedge clk); init = 1'b0;
            n_cmp++;
            if (s_done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept sel=%0d: got done=%b want 0", sel, s_done); end
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            n_cmp++;
            if (s_done !== 1'b1 || s_vld !== 1'b0) begin
                n_bad++; $display("FAIL b2b_abort sel=%0d: got done=%b vld=%b want 1 0", sel, s_done, s_vld);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (s_done !== 1'b1 || s_vld !== 1'b0 || obs !== '0) begin
            n_bad++; $display("FAIL %s sel=%0d: got done=%b vld=%b beat=%h want 1 0 all-zero", tag, sel, s_done, s_vld, obs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            check_reset_values("reset");
        end
    endtask

    task automatic test_basic_l1();
        sel = 0;
        set_cfg(4, 2, 0, 1, 0, 16, 0, 4);
        run_frame(100, 0, 0);
    endtask

    task automatic test_lanes4();
        sel = 1;
        set_cfg(6, 1, 0, 2, 0, 0, 0, 0);
        run_frame(100, 0, 0);
    endtask

    task automatic test_stall();
        sel = 0;
        set_cfg(4, 2, 0, 1, 0, 16, 0, 4);
        run_frame(50, 1, 0);
        sel = 1;
        rand_cfg(13, 3);
        run_frame(50, 1, 0);
    endtask

    task automatic test_stride();
        sel = 0;
        set_cfg(2, 3, 0, 1, 0, 1, 100, 640);
        run_frame(100, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            sel = it % 2;
            rand_cfg(11, 4);
            run_frame(65, 1, 0);
        end
    endtask

    task automatic test_zero_size();
        sel = 1;
        for (int z = 0; z < 2; z++) begin
            if (z == 0) set_cfg(0, 3, 1, 1, 1, 1, 0, 0);
            else        set_cfg(5, 0, 1, 1, 1, 1, 0, 0);
            @(negedge clk); init = 1'b1; rdy = 1'b1;
            @(negedge clk); init = 1'b0;
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (s_done !== 1'b1 || s_vld !== 1'b0) begin
                    n_bad++; $display("FAIL zero_size w=%0d h=%0d: got done=%b vld=%b want 1 0", width, height, s_done, s_vld);
                end
                @(negedge clk);
            end
        end
        rdy = 1'b0;
    endtask

    task automatic test_abort();
        sel = 1;
        rand_cfg(1, 1);
        width = CW'(14); height = CW'(3);
        build_expected(4);
        @(negedge clk); rdy = 1'b0; init = 1'b1;
        @(negedge clk); init = 1'b0;
        for (int i = 0; i < 10 && s_vld !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (s_vld !== 1'b1) begin n_bad++; $display("FAIL abort_start: got vld=%b want 1", s_vld); end
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk); rdy = 1'b0;
        n_cmp++;
        if (obs !== exp_q[2]) begin n_bad++; $display("FAIL abort_beat2: got %h want %h", obs, exp_q[2]); end
        init = 1'b1;
        @(negedge clk); init = 1'b0;
        n_cmp++;
        if (obs !== exp_q[2] || s_done !== 1'b0 || s_vld !== 1'b1) begin
            n_bad++; $display("FAIL init_in_run: got done=%b vld=%b %h want 0 1 %h", s_done, s_vld, obs, exp_q[2]);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_cmp++;
        if (s_vld !== 1'b0 || s_done !== 1'b1 || obs.mask !== 4'b0 || obs.eol !== 1'b0 || obs.eof !== 1'b0) begin
            n_bad++; $display("FAIL abort: got vld=%b done=%b mask=%b eol=%b eof=%b want 0 1 0 0 0",
                              s_vld, s_done, obs.mask, obs.eol, obs.eof);
        end
        run_frame(100, 0, 0);
    endtask

    task automatic test_rst_mid();
        sel = 1;
        rand_cfg(9, 2);
        @(negedge clk); rdy = 1'b0; init = 1'b1;
        @(negedge clk); init = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset_values("rst_prep");
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
        for (int i = 0; i < 10 && s_vld !== 1'b1; i++) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk); rdy = 1'b0; clk_en = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; clk_en = 1'b1;
        check_reset_values("rst_run_clken0");
        run_frame(70, 0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        set_cfg(4, 2, 0, 1, 0, 16, 0, 4);
        run_frame(100, 0, 1);
        sel = 1;
        rand_cfg(9, 2);
        run_frame(100, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic_l1();
        test_lanes4();
        test_stall();
        test_stride();
        test_zero_size();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
